ifid_stage: RTL and testbench

- Pipeline register between the IF stage and the ID stage of the MIPS-III pipeline. Drives the ID-stage instruction and its bookkeeping signals: ID_Instruction, ID_PCAdd4, ID_RestartPC, ID_IsBDS, ID_IsFlushed.
- Injects bubbles on fetch stall or flush, and holds its contents on decode stall.
- A one-entry skid buffer keeps a single-cycle instruction-memory response that arrives while ID is stalled.
- Keeps a bubble counter for performance monitoring.

---
 rtl/ifid_stage_if.sv | 36 +++
 rtl/ifid_stage.sv | 135 +++++++++++++
 tb/tb_ifid_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifid_stage_if.sv
// IF -> ID pipeline register bundle: fetch-side inputs, decode-side outputs.
// The stage itself uses the slave view; whoever drives fetch uses master.
interface ifid_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      IF_Instruction;
    logic             IF_InstValid;
    logic [31:0]      IF_PCAdd4;
    logic [31:0]      IF_PC;
    logic             IF_IsBDS;
    logic             IF_Stall;
    logic             IF_Flush;
    logic             ID_Stall;
    logic [31:0]      ID_Instruction;
    logic [31:0]      ID_PCAdd4;
    logic [31:0]      ID_RestartPC;
    logic             ID_IsBDS;
    logic             ID_IsFlushed;
    logic             ID_Valid;
    logic             SkidFull;
    logic [CNT_W-1:0] BubbleCount;

    modport master (
        output IF_Instruction, IF_InstValid, IF_PCAdd4, IF_PC, IF_IsBDS,
               IF_Stall, IF_Flush, ID_Stall,
        input  ID_Instruction, ID_PCAdd4, ID_RestartPC, ID_IsBDS,
               ID_IsFlushed, ID_Valid, SkidFull, BubbleCount
    );

    modport slave (
        input  IF_Instruction, IF_InstValid, IF_PCAdd4, IF_PC, IF_IsBDS,
               IF_Stall, IF_Flush, ID_Stall,
        output ID_Instruction, ID_PCAdd4, ID_RestartPC, ID_IsBDS,
               ID_IsFlushed, ID_Valid, SkidFull, BubbleCount
    );
endinterface

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with bubble injection, decode-stall hold,
// a one-entry skid buffer for late fetch responses and a saturating
// bubble counter. Every output comes straight from a register.
module ifid_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic clock,
    input  logic reset,
    ifid_stage_if.slave bus
);
    // ID-side registers
    logic [31:0]      instrReg, instrNext;
    logic [31:0]      pcAdd4Reg, pcAdd4Next;
    logic [31:0]      restartPcReg, restartPcNext;
    logic             isBdsReg, isBdsNext;
    logic             isFlushedReg, isFlushedNext;
    logic             validReg, validNext;
    logic [CNT_W-1:0] bubbleCountReg, bubbleCountNext;

    // Skid entry
    logic             skidFullReg, skidFullNext;
    logic [31:0]      skidInstrReg, skidInstrNext;
    logic [31:0]      skidPcAdd4Reg, skidPcAdd4Next;
    logic [31:0]      skidPcReg, skidPcNext;
    logic             skidIsBdsReg, skidIsBdsNext;

    // Source mux: a held skid entry always wins over the live fetch word
    logic [31:0] srcInstr, srcPcAdd4, srcPc;
    logic        srcIsBds, liveValid, srcValid, bubbleInc;

    assign liveValid = bus.IF_InstValid & ~bus.IF_Stall;
    assign srcValid  = skidFullReg | liveValid;
    assign srcInstr  = skidFullReg ? skidInstrReg  : bus.IF_Instruction;
    assign srcPcAdd4 = skidFullReg ? skidPcAdd4Reg : bus.IF_PCAdd4;
    assign srcPc     = skidFullReg ? skidPcReg     : bus.IF_PC;
    assign srcIsBds  = skidFullReg ? skidIsBdsReg  : bus.IF_IsBDS;

    // Next-state selection: stall hold, flush bubble, empty bubble, or load
    always_comb begin
        instrNext      = instrReg;
        pcAdd4Next     = pcAdd4Reg;
        restartPcNext  = restartPcReg;
        isBdsNext      = isBdsReg;
        isFlushedNext  = isFlushedReg;
        validNext      = validReg;
        skidFullNext   = skidFullReg;
        skidInstrNext  = skidInstrReg;
        skidPcAdd4Next = skidPcAdd4Reg;
        skidPcNext     = skidPcReg;
        skidIsBdsNext  = skidIsBdsReg;
        bubbleInc      = 1'b0;

        if (bus.ID_Stall) begin
            // Outputs hold; a flush during the stall only discards the skid,
            // the controller repeats the flush once the stall releases.
            if (bus.IF_Flush) begin
                skidFullNext = 1'b0;
            end else if (liveValid && !skidFullReg) begin
                skidFullNext   = 1'b1;
                skidInstrNext  = bus.IF_Instruction;
                skidPcAdd4Next = bus.IF_PCAdd4;
                skidPcNext     = bus.IF_PC;
                skidIsBdsNext  = bus.IF_IsBDS;
            end
        end else if (bus.IF_Flush) begin
            instrNext     = NOP_WORD;
            isFlushedNext = 1'b1;
            validNext     = 1'b0;
            isBdsNext     = 1'b0;
            skidFullNext  = 1'b0;
            bubbleInc     = 1'b1;
        end else if (!srcValid) begin
            // PCs hold so an exception on the bubble restarts at the last real PC
            instrNext     = NOP_WORD;
            isFlushedNext = 1'b0;
            validNext     = 1'b0;
            isBdsNext     = 1'b0;
            bubbleInc     = 1'b1;
        end else begin
            // Draining the skid ignores the live word: IF is held off by SkidFull
            instrNext     = srcInstr;
            pcAdd4Next    = srcPcAdd4;
            restartPcNext = srcPc;
            isBdsNext     = srcIsBds;
            isFlushedNext = 1'b0;
            validNext     = 1'b1;
            skidFullNext  = 1'b0;
        end

        bubbleCountNext = bubbleCountReg;
        if (bubbleInc && !(&bubbleCountReg))
            bubbleCountNext = bubbleCountReg + CNT_W'(1);
    end

    // State update; reset overrides stalls and drops any skid contents
    always_ff @(posedge clock) begin
        if (reset) begin
            instrReg       <= NOP_WORD;
            pcAdd4Reg      <= 32'h0;
            restartPcReg   <= 32'h0;
            isBdsReg       <= 1'b0;
            isFlushedReg   <= 1'b0;
            validReg       <= 1'b0;
            bubbleCountReg <= '0;
            skidFullReg    <= 1'b0;
            skidInstrReg   <= 32'h0;
            skidPcAdd4Reg  <= 32'h0;
            skidPcReg      <= 32'h0;
            skidIsBdsReg   <= 1'b0;
        end else begin
            instrReg       <= instrNext;
            pcAdd4Reg      <= pcAdd4Next;
            restartPcReg   <= restartPcNext;
            isBdsReg       <= isBdsNext;
            isFlushedReg   <= isFlushedNext;
            validReg       <= validNext;
            bubbleCountReg <= bubbleCountNext;
            skidFullReg    <= skidFullNext;
            skidInstrReg   <= skidInstrNext;
            skidPcAdd4Reg  <= skidPcAdd4Next;
            skidPcReg      <= skidPcNext;
            skidIsBdsReg   <= skidIsBdsNext;
        end
    end

    assign bus.ID_Instruction = instrReg;
    assign bus.ID_PCAdd4      = pcAdd4Reg;
    assign bus.ID_RestartPC   = restartPcReg;
    assign bus.ID_IsBDS       = isBdsReg;
    assign bus.ID_IsFlushed   = isFlushedReg;
    assign bus.ID_Valid       = validReg;
    assign bus.SkidFull       = skidFullReg;
    assign bus.BubbleCount    = bubbleCountReg;
endmodule

// File: tb/tb_ifid_stage.sv
// Bench for ifid_stage: directed vector table, reset/saturation sequences,
// and randomized traffic against a queue-based reference model.
module tb_ifid_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifid_stage_if #(.CNT_W(16)) busA ();
    ifid_stage_if #(.CNT_W(4))  busB ();

    ifid_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(16)) dut (
        .clock(clk), .reset(rst), .bus(busA)
    );
    ifid_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(4)) dutSat (
        .clock(clk), .reset(rst), .bus(busB)
    );

    // Small counter instance sees nothing but fetch stalls
    assign busB.IF_Instruction = 32'h0;
    assign busB.IF_InstValid   = 1'b0;
    assign busB.IF_PCAdd4      = 32'h0;
    assign busB.IF_PC          = 32'h0;
    assign busB.IF_IsBDS       = 1'b0;
    assign busB.IF_Stall       = 1'b1;
    assign busB.IF_Flush       = 1'b0;
    assign busB.ID_Stall       = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcAdd4;
        logic [31:0] restartPc;
        logic        isBds;
        logic        isFlushed;
        logic        valid;
        logic        skidFull;
        int          count;
    } outs_t;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bds;
        logic        ifStall;
        logic        flush;
        logic        idStall;
        outs_t       exp;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bds;
    } entry_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    outs_t  mId;
    entry_t mSkid[$];
    int     mCount;
    localparam int CNT_MAX = 65535;

    vec_t vecs[14];

    function automatic outs_t mkOuts(logic [31:0] i, logic [31:0] pa, logic [31:0] rp,
                                     logic b, logic f, logic v, logic s, int c);
        outs_t o;
        o.instr = i; o.pcAdd4 = pa; o.restartPc = rp; o.isBds = b;
        o.isFlushed = f; o.valid = v; o.skidFull = s; o.count = c;
        return o;
    endfunction

    function automatic vec_t mkVec(logic iv, logic [31:0] instr, logic [31:0] pc, logic bds,
                                   logic ifs, logic fl, logic ids, outs_t e);
        vec_t v;
        v.iv = iv; v.instr = instr; v.pc = pc; v.bds = bds;
        v.ifStall = ifs; v.flush = fl; v.idStall = ids; v.exp = e;
        return v;
    endfunction

    task automatic applyIn(logic r, logic iv, logic [31:0] instr, logic [31:0] pc, logic bds,
                           logic ifs, logic fl, logic ids);
        rst                 = r;
        busA.IF_InstValid   = iv;
        busA.IF_Instruction = instr;
        busA.IF_PC          = pc;
        busA.IF_PCAdd4      = pc + 32'd4;
        busA.IF_IsBDS       = bds;
        busA.IF_Stall       = ifs;
        busA.IF_Flush       = fl;
        busA.ID_Stall       = ids;
    endtask

    // Behavioural model of one edge, written from the stage's rules
    task automatic modelStep();
        entry_t e;
        logic   bubble;
        bubble = 1'b0;
        if (rst) begin
            mId = mkOuts(32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
            mSkid.delete();
            mCount = 0;
        end else if (busA.ID_Stall) begin
            if (busA.IF_Flush)
                mSkid.delete();
            else if (busA.IF_InstValid && !busA.IF_Stall && mSkid.size() == 0) begin
                e.instr = busA.IF_Instruction; e.pc = busA.IF_PC; e.bds = busA.IF_IsBDS;
                mSkid.push_back(e);
            end
        end else if (busA.IF_Flush) begin
            mSkid.delete();
            mId.instr = 32'h0; mId.isFlushed = 1; mId.valid = 0; mId.isBds = 0;
            bubble = 1'b1;
        end else if (mSkid.size() != 0 || (busA.IF_InstValid && !busA.IF_Stall)) begin
            if (mSkid.size() != 0) begin
                e = mSkid.pop_front();
            end else begin
                e.instr = busA.IF_Instruction; e.pc = busA.IF_PC; e.bds = busA.IF_IsBDS;
            end
            mId.instr = e.instr; mId.restartPc = e.pc; mId.pcAdd4 = e.pc + 32'd4;
            mId.isBds = e.bds; mId.valid = 1; mId.isFlushed = 0;
        end else begin
            mId.instr = 32'h0; mId.valid = 0; mId.isFlushed = 0; mId.isBds = 0;
            bubble = 1'b1;
        end
        if (bubble && mCount < CNT_MAX) mCount++;
        mId.skidFull = (mSkid.size() != 0);
        mId.count    = mCount;
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOuts(string tag, outs_t e);
        cmp({tag, " ID_Instruction"}, busA.ID_Instruction, e.instr);
        cmp({tag, " ID_PCAdd4"},      busA.ID_PCAdd4,      e.pcAdd4);
        cmp({tag, " ID_RestartPC"},   busA.ID_RestartPC,   e.restartPc);
        cmp({tag, " ID_IsBDS"},       {31'h0, busA.ID_IsBDS},     {31'h0, e.isBds});
        cmp({tag, " ID_IsFlushed"},   {31'h0, busA.ID_IsFlushed}, {31'h0, e.isFlushed});
        cmp({tag, " ID_Valid"},       {31'h0, busA.ID_Valid},     {31'h0, e.valid});
        cmp({tag, " SkidFull"},       {31'h0, busA.SkidFull},     {31'h0, e.skidFull});
        cmp({tag, " BubbleCount"},    {16'h0, busA.BubbleCount},  e.count);
    endtask

    // Protocol guard: no fetch response while the skid is full and ID stalls
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(busA.SkidFull && busA.ID_Stall && busA.IF_InstValid))
            else begin
                errors++;
                $display("FAIL protocol: IF_InstValid=%0d with SkidFull=%0d ID_Stall=%0d",
                         busA.IF_InstValid, busA.SkidFull, busA.ID_Stall);
            end
        end
    end

    initial begin
        int expSat;
        string tag;
        //                 iv  instr          pc       bds ifs fl ids   instr          pa4      rpc      bds fl v skid cnt
        vecs[0]  = mkVec(1, 32'h2008_0005, 32'h100, 0, 0, 0, 0, mkOuts(32'h2008_0005, 32'h104, 32'h100, 0, 0, 1, 0, 0));
        vecs[1]  = mkVec(1, 32'h8C09_0000, 32'h104, 0, 0, 0, 1, mkOuts(32'h2008_0005, 32'h104, 32'h100, 0, 0, 1, 1, 0));
        vecs[2]  = mkVec(0, 32'h0,         32'h0,   0, 0, 0, 1, mkOuts(32'h2008_0005, 32'h104, 32'h100, 0, 0, 1, 1, 0));
        vecs[3]  = mkVec(0, 32'h0,         32'h0,   0, 0, 0, 1, mkOuts(32'h2008_0005, 32'h104, 32'h100, 0, 0, 1, 1, 0));
        vecs[4]  = mkVec(0, 32'h0,         32'h0,   0, 0, 0, 0, mkOuts(32'h8C09_0000, 32'h108, 32'h104, 0, 0, 1, 0, 0));
        vecs[5]  = mkVec(1, 32'h1111_2222, 32'h108, 0, 0, 1, 0, mkOuts(32'h0,         32'h108, 32'h104, 0, 1, 0, 0, 1));
        vecs[6]  = mkVec(1, 32'h0,         32'h20C, 1, 0, 0, 0, mkOuts(32'h0,         32'h210, 32'h20C, 1, 0, 1, 0, 1));
        vecs[7]  = mkVec(1, 32'hDEAD_BEEF, 32'h210, 0, 1, 0, 0, mkOuts(32'h0,         32'h210, 32'h20C, 0, 0, 0, 0, 2));
        vecs[8]  = mkVec(1, 32'h1234_5678, 32'h300, 0, 0, 0, 0, mkOuts(32'h1234_5678, 32'h304, 32'h300, 0, 0, 1, 0, 2));
        vecs[9]  = mkVec(1, 32'h5555_6666, 32'h304, 0, 0, 1, 1, mkOuts(32'h1234_5678, 32'h304, 32'h300, 0, 0, 1, 0, 2));
        vecs[10] = mkVec(0, 32'h0,         32'h0,   0, 0, 0, 0, mkOuts(32'h0,         32'h304, 32'h300, 0, 0, 0, 0, 3));
        vecs[11] = mkVec(1, 32'hAAAA_0001, 32'h400, 0, 0, 0, 1, mkOuts(32'h0,         32'h304, 32'h300, 0, 0, 0, 1, 3));
        vecs[12] = mkVec(0, 32'h0,         32'h0,   0, 0, 1, 1, mkOuts(32'h0,         32'h304, 32'h300, 0, 0, 0, 0, 3));
        vecs[13] = mkVec(0, 32'h0,         32'h0,   0, 0, 0, 0, mkOuts(32'h0,         32'h304, 32'h300, 0, 0, 0, 0, 4));

        mId = mkOuts(32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        mCount = 0;

        // Reset state
        applyIn(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        step();
        checkOuts("reset", mkOuts(32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
        $display("txn reset: ID_Instruction=%h BubbleCount=%0d", busA.ID_Instruction, busA.BubbleCount);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            applyIn(0, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].bds,
                    vecs[i].ifStall, vecs[i].flush, vecs[i].idStall);
            step();
            tag = $sformatf("vec%0d", i);
            checkOuts(tag, vecs[i].exp);
            $display("txn vec%0d: ID_Instruction=%h RestartPC=%h Valid=%0d Skid=%0d Count=%0d",
                     i, busA.ID_Instruction, busA.ID_RestartPC, busA.ID_Valid,
                     busA.SkidFull, busA.BubbleCount);
        end

        // Reset with skid full in the middle of a decode stall
        applyIn(0, 1, 32'hCAFE_0001, 32'h500, 1, 0, 0, 1);
        step();
        cmp("midreset pre SkidFull", {31'h0, busA.SkidFull}, 32'h1);
        applyIn(1, 0, 32'h0, 32'h0, 0, 0, 0, 1);
        step();
        checkOuts("midreset", mkOuts(32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
        cmp("sat after reset", {28'h0, busB.BubbleCount}, 32'h0);
        $display("txn midreset: SkidFull=%0d ID_Valid=%0d", busA.SkidFull, busA.ID_Valid);

        // Saturation of the 4-bit counter under continuous fetch stall
        applyIn(0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            expSat = (k < 15) ? k : 15;
            cmp($sformatf("sat cycle%0d BubbleCount", k), {28'h0, busB.BubbleCount}, expSat);
            $display("txn sat%0d: BubbleCount=%0d", k, busB.BubbleCount);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic r, iv, ifs, fl, ids, bds;
            logic [31:0] instr, pc;
            r     = ($urandom_range(0, 79) == 0);
            iv    = ($urandom_range(0, 2) != 0);
            ifs   = ($urandom_range(0, 4) == 0);
            fl    = ($urandom_range(0, 11) == 0);
            ids   = ($urandom_range(0, 2) == 0);
            bds   = $urandom_range(0, 1);
            instr = $urandom;
            pc    = $urandom & 32'hFFFF_FFFC;
            if (mSkid.size() != 0 && ids) iv = 1'b0;
            applyIn(r, iv, instr, pc, bds, ifs, fl, ids);
            step();
            tag = $sformatf("rand%0d", n);
            checkOuts(tag, mId);
            $display("txn rand%0d: rst=%0d iv=%0d ifs=%0d fl=%0d ids=%0d -> instr=%h v=%0d skid=%0d cnt=%0d",
                     n, r, iv, ifs, fl, ids, busA.ID_Instruction, busA.ID_Valid,
                     busA.SkidFull, busA.BubbleCount);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
